ahb_sram_responder: RTL
=======================

Name: ahb_sram_responder

Overview:
AHB-Lite subordinate that answers the requests of the cache/uncached bus initiator. It serves single transfers and cache-line bursts from an on-block word-wide SRAM. Used as the memory model behind the IFU/LSU bus in block-level and core-level benches, and as a small on-chip RAM. It implements address/data phase pipelining, HWSTRB byte writes, wait states and a two-cycle ERROR response.

Parameters:
- AHBW, 64, bus data width in bits (32 or 64).
- PA_BITS, 56, physical address width.
- DEPTH, 4096, number of AHBW-bit words in the array.
- BASE, 0, byte base address of the array; must be aligned to DEPTH*AHBW/8.
- WAITSTATES, 0, wait cycles inserted per data phase; used only with the optional feature.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  decoder select for this subordinate.
- HADDR  in  PA_BITS  address-phase address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; informational, not checked.
- HWDATA  in  AHBW  data-phase write data.
- HWSTRB  in  AHBW/8  data-phase byte strobes.
- HREADY  in  1  bus-level ready from the interconnect.
- HREADYOUT  out  1  this subordinate's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  AHBW  read data.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, data-phase registers cleared. The array is not cleared.
- Accept condition: HSEL & HREADY & HTRANS[1]. On the accepting edge, latch address, write flag, size and an error flag into data-phase registers.
- Error flag is set when any of these hold:
  - address is outside [BASE, BASE+DEPTH*AHBW/8);
  - HSIZE > log2(AHBW/8);
  - address is not aligned to HSIZE.
- IDLE or BUSY, or HSEL=0: no access; next data phase is OKAY with HREADYOUT=1.
- Word index = (HADDR-BASE) >> log2(AHBW/8), width log2(DEPTH).
- Read: the array is read on the accepting edge. HRDATA is valid in the data-phase cycle in which HREADYOUT=1, so zero-wait read latency is one cycle.
- Write: HWDATA/HWSTRB are sampled during the data phase. The array is written only on the edge where HREADYOUT=1 and the data-phase error flag is 0. Bytes with HWSTRB=0 are unchanged.
- Read-after-write forwarding: when a read is accepted on the same edge that completes a write to the same word, HRDATA returns the merged (new) bytes.
- FSM states:
  - IDLE: no pending data phase.
  - DATA: zero-wait completion.
  - WAIT: counting wait states.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on an accepted transfer:
  - error flag → ERR1 → ERR2 → IDLE, or to the next accepted transfer.
  - otherwise → DATA, or WAIT if the wait count is nonzero.
- Pipelining: back-to-back bursts (e.g. INCR4 SEQ beats) complete one beat per cycle at zero wait. A new transfer is accepted in the same cycle the previous data phase completes.
- An erroneous transfer never writes. No new transfer is accepted during ERR1, because HREADY=0.
- Reset asserted mid-burst or mid-wait: the pending data phase is discarded, no write occurs, and all outputs take reset values on the next edge.
- HRDATA holds its last value outside read data phases.

Optional Feature:
- Macro AHB_SRAM_RESPONDER_WAITSTATE_EN.
- Defined: each accepted non-error transfer holds HREADYOUT=0 for WAITSTATES cycles (FSM state WAIT, down-counter of width $clog2(WAITSTATES+1)), then completes.
  - Read data and the write commit occur in the completion cycle.
  - HWDATA must be held stable by the initiator throughout the data phase and is sampled in the completion cycle.
- Undefined: the WAIT state and counter are absent; every non-error transfer is zero-wait.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HBURST encodings (SINGLE, INCR, INCR4/8/16);
  - HRESP encodings;
  - responder FSM state enum.
- One sub-module: ahb_sram_bytearray, a synchronous-read, byte-enable-write RAM of DEPTH×AHBW.

Test Plan:
- Zero-wait single: write 0x1122334455667788 to 0x100 with HWSTRB=0xFF, then read 0x100 → HRDATA=0x1122334455667788, HRESP=0, one-cycle latency.
- Byte strobe: over 0x1122334455667788, write 0xAAAAAAAAAAAAAAAA with HWSTRB=0x0F → read returns 0x11223344AAAAAAAA.
- Burst: INCR4 read at 0x200 after writing 0,1,2,3 to 0x200..0x218 → 4 consecutive HREADYOUT=1 beats returning 0,1,2,3.
- Forwarding: write 0xDEAD at 0x40 immediately followed by a read of 0x40 → HRDATA=0xDEAD.
- Error: read at BASE+DEPTH*8 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Write to the same address leaves the array unchanged.
- With the macro defined and WAITSTATES=2: single read → HREADYOUT low for 2 cycles, data on the third. Assert HRESET during the wait → outputs reset and no write committed.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
// AHB_SRAM_RESPONDER_WAITSTATE_EN adds the WAIT state used for inserted wait cycles.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_INCR4  = 3'b011,
      HBURST_INCR8  = 3'b101,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } rsp_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } rsp_state_e;
`endif

endpackage

// File: rtl/ahb_sram_bytearray.sv
// Synchronous-read, byte-enable-write RAM of DEPTH x AHBW, one byte lane per array.
// A read addressing the word written on the same edge returns the merged new bytes.
module ahb_sram_bytearray #(
   parameter int AHBW  = 64,
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [AHBW-1:0]          rdata,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [AHBW-1:0]          wdata,
   input  logic [AHBW/8-1:0]        wstrb
);

   localparam int NB = AHBW / 8;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
               mem[waddr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
               if (we && wstrb[gi] && (waddr == raddr)) begin
                  rd_q <= wdata[gi*8 +: 8];
               end else begin
                  rd_q <= mem[raddr];
               end
            end
         end

         assign rdata[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite subordinate serving single transfers and bursts from an on-block SRAM.
// Define AHB_SRAM_RESPONDER_WAITSTATE_EN to insert WAITSTATES wait cycles per good transfer.
module ahb_sram_responder
   import ahb_pkg::*;
#(
   parameter int                  AHBW       = 64,
   parameter int                  PA_BITS    = 56,
   parameter int                  DEPTH      = 4096,
   parameter logic [PA_BITS-1:0]  BASE       = '0,
   parameter int                  WAITSTATES = 0
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                HSEL,
   input  logic [PA_BITS-1:0]  HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [2:0]          HBURST,
   input  logic [AHBW-1:0]     HWDATA,
   input  logic [AHBW/8-1:0]   HWSTRB,
   input  logic                HREADY,
   output logic                HREADYOUT,
   output logic                HRESP,
   output logic [AHBW-1:0]     HRDATA
);

   localparam int BYTE_LG = $clog2(AHBW / 8);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int SPAN_LG = IDX_W + BYTE_LG;
   localparam logic [PA_BITS-1:SPAN_LG] BASE_HI = BASE[PA_BITS-1:SPAN_LG];

   rsp_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [AHBW-1:0]   hrdata_q, hrdata_d;
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
   localparam int CNT_W = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   logic              accept;
   logic              addr_err;
   logic [6:0]        size_mask;
   logic              rd_phase;
   logic              ram_re, ram_we;
   logic [IDX_W-1:0]  ram_raddr;
   logic [AHBW-1:0]   ram_rdata;
   logic              unused_ok;

   // BASE is span-aligned, so the range test is a compare of the bits above the span.
   always_comb begin
      size_mask = (7'd1 << HSIZE) - 7'd1;
      addr_err  = (HADDR[PA_BITS-1:SPAN_LG] != BASE_HI)
               || (HSIZE > 3'(BYTE_LG))
               || ((HADDR[6:0] & size_mask) != 7'd0);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
      cnt_d     = cnt_q;
`endif
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;

      case (state_q)
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_DATA;
         end
`endif
         default: ;
      endcase

      // New address phases are only taken in cycles where our own data phase completes.
      accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
      if (HREADYOUT) begin
         if (accept) begin
            idx_d = HADDR[SPAN_LG-1:BYTE_LG];
            wr_d  = HWRITE;
            if (addr_err) begin
               state_d = ST_ERR1;
            end
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
            else if (WAITSTATES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(WAITSTATES);
            end
`endif
            else begin
               state_d = ST_DATA;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   assign rd_phase  = (state_q == ST_DATA) && !wr_q;
   assign ram_raddr = HADDR[SPAN_LG-1:BYTE_LG];
   assign ram_re    = accept && !HWRITE && !addr_err && !HRESET;
   assign ram_we    = (state_q == ST_DATA) && wr_q && !HRESET;
   assign HRDATA    = rd_phase ? ram_rdata : hrdata_q;
   assign hrdata_d  = HRDATA;
   assign unused_ok = ^{HBURST, HTRANS[0], (WAITSTATES != 0)};

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         hrdata_q <= '0;
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wr_q     <= wr_d;
         hrdata_q <= hrdata_d;
`ifdef AHB_SRAM_RESPONDER_WAITSTATE_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   ahb_sram_bytearray #(
      .AHBW  (AHBW),
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (HCLK),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata),
      .we    (ram_we),
      .waddr (idx_q),
      .wdata (HWDATA),
      .wstrb (HWSTRB)
   );

endmodule
